config_chain_driver: RTL and testbench

- Initiator for a serial config/scan shift chain (configIn/configEn/configClk in, configOut back); it is the other end of the chain's shift-register responder.
- Takes a parallel word, shifts it MSB-first into a NUM_BITS-long chain using a divided, glitch-free configClk.
- Simultaneously captures the chain's previous contents from configOut, giving write-and-readback in one transaction.
- Sits between an SPI-mapped register bank (wr_data/start/rd_data) and the array config/scan switch matrix.

---
 rtl/config_chain_pkg.sv | 16 +
 rtl/cfg_phase_timer.sv | 41 ++++
 rtl/config_chain_driver.sv | 161 ++++++++++++++++
 tb/tb_config_chain_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/config_chain_pkg.sv
// Shared types and helpers for the serial config-chain initiator.
package config_chain_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } cfg_state_t;

  function automatic int cnt_width(input int num_bits);
    return $clog2(num_bits + 1);
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Counts CLK_DIV system clocks per configClk half-period and strobes phase_end_o
// on the last cycle of each phase; clr_i restarts the count on state entry.
module cfg_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr_i,
  output logic phase_end_o
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] cnt_q;
  logic [PH_W-1:0] cnt_d;

  // Phase counter next-state: restart on clear or wrap at the end of a phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (phase_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PH_W'(1);
    end
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == LAST);

endmodule

// File: rtl/config_chain_driver.sv
// Serial config-chain initiator: shifts a parallel word MSB-first into the chain
// on a divided configClk while capturing the old chain contents from configOut.
module config_chain_driver
  import config_chain_pkg::*;
#(
  parameter int NUM_BITS = 100,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                start,
  input  logic [NUM_BITS-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] rd_data,
  output logic                configClk,
  output logic                configEn,
  output logic                configIn,
  input  logic                configOut
);

  localparam int CNT_W = cnt_width(NUM_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(NUM_BITS);

  cfg_state_t          state_q, state_d;
  logic [NUM_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [NUM_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [NUM_BITS-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cclk_q, cclk_d;
  logic                cen_q, cen_d;
  logic                cin_q, cin_d;
  logic                phase_end_s;
  logic                phase_clr_s;

  assign phase_clr_s = (state_d != state_q) || (state_q == IDLE);

  cfg_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_timer (
    .clk         (clk),
    .reset_b     (reset_b),
    .clr_i       (phase_clr_s),
    .phase_end_o (phase_end_s)
  );

  // Transaction FSM: next state and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rd_data_d = rd_data_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cclk_d    = cclk_q;
    cen_d     = cen_q;
    cin_d     = cin_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (start) begin
          state_d = LOW;
          tx_sr_d = wr_data;
          busy_d  = 1'b1;
          cen_d   = 1'b1;
          cin_d   = wr_data[NUM_BITS-1];
          cclk_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOW: begin
        // configOut is sampled here, before the chain shifts on the rising configClk.
        if (phase_end_s) begin
          cclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[NUM_BITS-2:0], configOut};
          state_d = HIGH;
        end else begin
          state_d = LOW;
        end
      end
      HIGH: begin
        if (phase_end_s) begin
          cclk_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = ALL_BITS;
            state_d   = TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_sr_d   = tx_sr_q << 1;
            cin_d     = tx_sr_q[NUM_BITS-2];
            state_d   = LOW;
          end
        end else begin
          state_d = HIGH;
        end
      end
      TAIL: begin
        if (phase_end_s) begin
          cen_d   = 1'b0;
          cin_d   = 1'b0;
          state_d = DONE;
        end else begin
          state_d = TAIL;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        rd_data_d = rx_sr_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cclk_d  = 1'b0;
        cen_d   = 1'b0;
        cin_d   = 1'b0;
      end
    endcase
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rd_data_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cclk_q    <= 1'b0;
      cen_q     <= 1'b0;
      cin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rd_data_q <= rd_data_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cclk_q    <= cclk_d;
      cen_q     <= cen_d;
      cin_q     <= cin_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign configClk = cclk_q;
  assign configEn  = cen_q;
  assign configIn  = cin_q;

endmodule

// File: tb/tb_config_chain_driver.sv
// Bench for config_chain_driver: three instances (8/2, 100/4, 8/1), each driving
// a behavioural shift-register chain; a table, hand sequences and random writes.
module tb_config_chain_driver;

  logic clk = 1'b0;
  logic reset_b = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: NUM_BITS=8, CLK_DIV=2
  logic        a_start = 1'b0;
  logic [7:0]  a_wr = 8'h00;
  logic        a_busy, a_done, a_cclk, a_en, a_in, a_out;
  logic [7:0]  a_rd;
  logic [7:0]  a_chain;
  int          a_rises = 0;
  // Instance B: NUM_BITS=100, CLK_DIV=4
  logic        b_start = 1'b0;
  logic [99:0] b_wr = 100'h0;
  logic        b_busy, b_done, b_cclk, b_en, b_in, b_out;
  logic [99:0] b_rd;
  logic [99:0] b_chain;
  int          b_rises = 0;
  // Instance C: NUM_BITS=8, CLK_DIV=1
  logic        c_start = 1'b0;
  logic [7:0]  c_wr = 8'h00;
  logic        c_busy, c_done, c_cclk, c_en, c_in, c_out;
  logic [7:0]  c_rd;
  logic [7:0]  c_chain;
  int          c_rises = 0;

  config_chain_driver #(.NUM_BITS(8), .CLK_DIV(2)) dut_a (
    .clk(clk), .reset_b(reset_b), .start(a_start), .wr_data(a_wr), .busy(a_busy),
    .done(a_done), .rd_data(a_rd), .configClk(a_cclk), .configEn(a_en),
    .configIn(a_in), .configOut(a_out));
  config_chain_driver dut_b (
    .clk(clk), .reset_b(reset_b), .start(b_start), .wr_data(b_wr), .busy(b_busy),
    .done(b_done), .rd_data(b_rd), .configClk(b_cclk), .configEn(b_en),
    .configIn(b_in), .configOut(b_out));
  config_chain_driver #(.NUM_BITS(8), .CLK_DIV(1)) dut_c (
    .clk(clk), .reset_b(reset_b), .start(c_start), .wr_data(c_wr), .busy(c_busy),
    .done(c_done), .rd_data(c_rd), .configClk(c_cclk), .configEn(c_en),
    .configIn(c_in), .configOut(c_out));

  // Behavioural chains (the responder end).
  always @(posedge a_cclk or negedge reset_b)
    if (!reset_b) a_chain <= 8'h00; else if (a_en) a_chain <= {a_chain[6:0], a_in};
  always @(posedge b_cclk or negedge reset_b)
    if (!reset_b) b_chain <= 100'h0; else if (b_en) b_chain <= {b_chain[98:0], b_in};
  always @(posedge c_cclk or negedge reset_b)
    if (!reset_b) c_chain <= 8'h00; else if (c_en) c_chain <= {c_chain[6:0], c_in};
  assign a_out = a_chain[7];
  assign b_out = b_chain[99];
  assign c_out = c_chain[7];

  always @(posedge a_cclk) a_rises <= a_rises + 1;
  always @(posedge b_cclk) b_rises <= b_rises + 1;
  always @(posedge c_cclk) c_rises <= c_rises + 1;

  // Model: what each chain holds now, i.e. the expected next readback.
  logic [99:0] prev [3];

  task automatic check(input string nm, input logic [99:0] act, input logic [99:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic get_busy(input int s);
    case (s) 0: return a_busy; 1: return b_busy; default: return c_busy; endcase
  endfunction
  function automatic logic get_done(input int s);
    case (s) 0: return a_done; 1: return b_done; default: return c_done; endcase
  endfunction
  function automatic logic [99:0] get_rd(input int s);
    case (s) 0: return {92'h0, a_rd}; 1: return b_rd; default: return {92'h0, c_rd}; endcase
  endfunction
  function automatic logic [99:0] get_chain(input int s);
    case (s) 0: return {92'h0, a_chain}; 1: return b_chain; default: return {92'h0, c_chain}; endcase
  endfunction
  function automatic int get_rises(input int s);
    case (s) 0: return a_rises; 1: return b_rises; default: return c_rises; endcase
  endfunction
  function automatic int n_of(input int s);
    return (s == 1) ? 100 : 8;
  endfunction
  function automatic int d_of(input int s);
    case (s) 0: return 2; 1: return 4; default: return 1; endcase
  endfunction

  task automatic set_in(input int s, input logic st, input logic [99:0] wd);
    case (s)
      0: begin a_start = st; a_wr = wd[7:0]; end
      1: begin b_start = st; b_wr = wd; end
      default: begin c_start = st; c_wr = wd[7:0]; end
    endcase
  endtask

  // One transaction; called at a negedge with the instance idle (or its done high).
  task automatic run_txn(input int s, input logic [99:0] wd, input logic [99:0] exp_rd,
                         input bit keep);
    int lat;
    int r0;
    int lat_exp;
    lat_exp = (2 * n_of(s) + 1) * d_of(s) + 1;
    r0 = get_rises(s);
    set_in(s, 1'b1, wd);
    @(negedge clk);
    if (!keep) set_in(s, 1'b0, wd);
    check("busy_after_start", 100'(get_busy(s)), 100'(1));
    lat = 0;
    while (get_done(s) !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check("done_latency", 100'(lat), 100'(lat_exp));
    check("rd_data", get_rd(s), exp_rd);
    check("chain_contents", get_chain(s), wd);
    check("clk_rises", 100'(get_rises(s) - r0), 100'(n_of(s)));
    check("busy_at_done", 100'(get_busy(s)), 100'(0));
    prev[s] = wd;
    if (!keep) begin
      @(negedge clk);
      check("done_one_cycle", 100'(get_done(s)), 100'(0));
    end
  endtask

  // Setup/hold and idle-quietness monitor for instance A.
  bit mon_en = 1'b0;
  initial begin
    int since_in;
    int since_rise;
    logic p_clk;
    logic p_in;
    since_in = 100; since_rise = 100; p_clk = 1'b0; p_in = 1'b0;
    forever begin
      @(negedge clk);
      if (since_in < 1000) since_in++;
      if (since_rise < 1000) since_rise++;
      if (mon_en) begin
        if (a_cclk && !p_clk) begin
          check("en_on_rise", 100'(a_en), 100'(1));
          check("setup_2clk", 100'(since_in >= 2), 100'(1));
          since_rise = 0;
        end
        if (a_in != p_in) begin
          check("hold_2clk", 100'(since_rise >= 2), 100'(1));
          since_in = 0;
        end
        if (!a_busy) begin
          check("idle_en_low", 100'(a_en), 100'(0));
          check("idle_clk_low", 100'(a_cclk), 100'(0));
        end
      end
      p_clk = a_cclk;
      p_in = a_in;
    end
  end

  typedef struct {
    logic [7:0] wr;
    logic [7:0] exp_rd;
    bit         keep;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int w;
    int r0;
    logic [99:0] pat;
    vecs[0] = '{wr: 8'hA5, exp_rd: 8'h00, keep: 1'b0};
    vecs[1] = '{wr: 8'h3C, exp_rd: 8'hA5, keep: 1'b1};
    vecs[2] = '{wr: 8'hFF, exp_rd: 8'h3C, keep: 1'b0};
    vecs[3] = '{wr: 8'h00, exp_rd: 8'hFF, keep: 1'b0};
    vecs[4] = '{wr: 8'h96, exp_rd: 8'h00, keep: 1'b0};
    vecs[5] = '{wr: 8'hC3, exp_rd: 8'h96, keep: 1'b0};
    for (int i = 0; i < 3; i++) prev[i] = 100'h0;

    #3 reset_b = 1'b0;
    #20;
    check("rst_busy", 100'(a_busy), 100'(0));
    check("rst_done", 100'(a_done), 100'(0));
    check("rst_cfg", 100'({a_cclk, a_en, a_in}), 100'(0));
    check("rst_rd_b", b_rd, 100'h0);
    @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // CLK_DIV=1 corner and the 100-bit default instance.
    run_txn(2, 100'h81, prev[2], 1'b0);
    pat = {50{2'b10}};
    run_txn(1, pat, prev[1], 1'b0);
    run_txn(1, 100'h0, pat, 1'b0);

    // Table vectors on A, including back-to-back with start held.
    for (int i = 0; i < 6; i++) begin
      run_txn(0, 100'(vecs[i].wr), 100'(vecs[i].exp_rd), vecs[i].keep);
    end

    // Reset in the middle of a transaction after three bits.
    mon_en = 1'b0;
    r0 = a_rises;
    set_in(0, 1'b1, 100'hA5);
    @(negedge clk);
    set_in(0, 1'b0, 100'hA5);
    w = 0;
    while ((a_rises - r0) < 3 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_wait", 100'(w < 200), 100'(1));
    #2 reset_b = 1'b0;
    #1;
    check("mid_rst_busy_done", 100'({a_busy, a_done}), 100'(0));
    check("mid_rst_cfg", 100'({a_cclk, a_en, a_in}), 100'(0));
    check("mid_rst_rd", 100'(a_rd), 100'(0));
    for (int i = 0; i < 3; i++) prev[i] = 100'h0;
    @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    run_txn(0, 100'h5A, prev[0], 1'b0);

    // Random writes against the model.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_txn(0, 100'($urandom_range(0, 255)), prev[0], 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(2, 100'($urandom_range(0, 255)), prev[2], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
